// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character LCD bus controllers.
package lcd_pkg;

    // Read controller states. The decision to re-poll or finish is taken on the
    // final ELOW edge so that back-to-back poll reads cost no extra clock.
    typedef enum logic [1:0] {
        RD_IDLE,
        RD_SETUP,
        RD_EHIGH,
        RD_ELOW
    } lcd_rd_state_t;

    // Register select encodings
    localparam logic LCD_RS_INSTR = 1'b0;
    localparam logic LCD_RS_DATA  = 1'b1;

    // Default bus timing at 10 MHz, shared with the write controller
    localparam int unsigned LCD_AS_CYCLES = 1;
    localparam int unsigned LCD_EH_CYCLES = 4;
    localparam int unsigned LCD_EL_CYCLES = 4;
    localparam int unsigned LCD_MAX_POLLS = 2000;

endpackage

// File: rtl/lcd_reader.sv
// Read-side controller for an HD44780-compatible LCD on the 8-bit bus.
// Performs RW=1 cycles returning BF/AC or a data byte, with optional
// busy-flag polling bounded by MAX_POLLS.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int unsigned AS_CYCLES = LCD_AS_CYCLES,
    parameter int unsigned EH_CYCLES = LCD_EH_CYCLES,
    parameter int unsigned EL_CYCLES = LCD_EL_CYCLES,
    parameter int unsigned MAX_POLLS = LCD_MAX_POLLS
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       req,
    input  logic       cmd_rs,
    input  logic       poll_bf,
    output logic       ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr,
    output logic       timeout,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    input  logic [7:0] lcd_data_in
);

    localparam logic [15:0] AS_LAST  = 16'(AS_CYCLES - 1);
    localparam logic [15:0] EH_LAST  = 16'(EH_CYCLES - 1);
    localparam logic [15:0] EL_LAST  = 16'(EL_CYCLES - 1);
    localparam logic [15:0] POLL_LIM = 16'(MAX_POLLS);

    lcd_rd_state_t state, state_nx;
    logic [15:0]   phase, phase_nx;
    logic [15:0]   polls, polls_nx;
    logic          rs_q, rs_nx;
    logic          poll_q, poll_nx;
    logic          poll_mode;
    logic          sample;
    logic          done;

    // Polling only applies to BF/AC reads
    assign poll_mode = poll_q && (rs_q == LCD_RS_INSTR);

    // State, phase counter, poll counter and captured command
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state  <= RD_IDLE;
            phase  <= '0;
            polls  <= '0;
            rs_q   <= LCD_RS_INSTR;
            poll_q <= 1'b0;
        end else begin
            state  <= state_nx;
            phase  <= phase_nx;
            polls  <= polls_nx;
            rs_q   <= rs_nx;
            poll_q <= poll_nx;
        end
    end

    // Next-state logic; one phase counter is reused by SETUP/EHIGH/ELOW
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        polls_nx = polls;
        rs_nx    = rs_q;
        poll_nx  = poll_q;
        sample   = 1'b0;
        done     = 1'b0;
        case (state)
            RD_IDLE: begin
                if (req) begin
                    state_nx = RD_SETUP;
                    phase_nx = '0;
                    polls_nx = '0;
                    rs_nx    = cmd_rs;
                    poll_nx  = poll_bf;
                end
            end
            RD_SETUP: begin
                if (phase == AS_LAST) begin
                    state_nx = RD_EHIGH;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase + 16'd1;
                end
            end
            RD_EHIGH: begin
                if (phase == EH_LAST) begin
                    state_nx = RD_ELOW;
                    phase_nx = '0;
                    sample   = 1'b1;
                    if (poll_mode && (polls != '1)) begin
                        polls_nx = polls + 16'd1;
                    end
                end else begin
                    phase_nx = phase + 16'd1;
                end
            end
            RD_ELOW: begin
                if (phase == EL_LAST) begin
                    phase_nx = '0;
                    if (poll_mode && busy_flag && (polls < POLL_LIM)) begin
                        state_nx = RD_SETUP;
                    end else begin
                        state_nx = RD_IDLE;
                        done     = 1'b1;
                    end
                end else begin
                    phase_nx = phase + 16'd1;
                end
            end
            default: begin
                state_nx = RD_IDLE;
                phase_nx = '0;
            end
        endcase
    end

    // Registered bus controls and results, decoded from the next state so
    // every output is a clean flop and reset drops E/RW immediately
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ready     <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            busy_flag <= 1'b0;
            addr      <= '0;
            timeout   <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_e     <= 1'b0;
        end else begin
            ready    <= (state_nx == RD_IDLE);
            lcd_e    <= (state_nx == RD_EHIGH);
            lcd_rw   <= (state_nx != RD_IDLE);
            lcd_rs   <= (state_nx != RD_IDLE) && rs_nx;
            rd_valid <= done;
            if (sample) begin
                rd_data <= lcd_data_in;
                timeout <= 1'b0;
                if (rs_q == LCD_RS_INSTR) begin
                    busy_flag <= lcd_data_in[7];
                    addr      <= lcd_data_in[6:0];
                end else begin
                    busy_flag <= 1'b0;
                end
            end
            if (done) begin
                timeout <= poll_mode && busy_flag;
            end
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// Directed self-checking bench for lcd_reader.
module tb_lcd_reader;

    logic       clk = 1'b0;
    logic       n_reset = 1'b1;
    logic       req = 1'b0;
    logic       req_t = 1'b0;
    logic       cmd_rs = 1'b0;
    logic       poll_bf = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;

    logic       ready, rd_valid, busy_flag, timeout, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] rd_data;
    logic [6:0] addr;
    logic       ready_t, rd_valid_t, busy_flag_t, timeout_t, lcd_rs_t, lcd_rw_t, lcd_e_t;
    logic [7:0] rd_data_t;
    logic [6:0] addr_t;

    int checks = 0;
    int errors = 0;

    // selected-instance views
    logic       sel = 1'b0;
    logic       s_e, s_rw, s_rs, s_rdy, s_v, s_bf, s_to;
    logic [7:0] s_data;
    logic [6:0] s_addr;

    // per-cycle history after edge k+j
    logic e_h [0:63];
    logic rw_h [0:63];
    logic rs_h [0:63];
    logic rdy_h [0:63];
    int         v_at, n_valid;
    logic [7:0] v_data;
    logic [6:0] v_addr;
    logic       v_bf, v_to;

    always #50 clk = ~clk;

    lcd_reader dut (
        .clk(clk), .n_reset(n_reset), .req(req), .cmd_rs(cmd_rs), .poll_bf(poll_bf),
        .ready(ready), .rd_valid(rd_valid), .rd_data(rd_data), .busy_flag(busy_flag),
        .addr(addr), .timeout(timeout), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data_in(lcd_data_in)
    );

    lcd_reader #(.MAX_POLLS(5)) dut_t (
        .clk(clk), .n_reset(n_reset), .req(req_t), .cmd_rs(cmd_rs), .poll_bf(poll_bf),
        .ready(ready_t), .rd_valid(rd_valid_t), .rd_data(rd_data_t), .busy_flag(busy_flag_t),
        .addr(addr_t), .timeout(timeout_t), .lcd_rs(lcd_rs_t), .lcd_rw(lcd_rw_t), .lcd_e(lcd_e_t),
        .lcd_data_in(lcd_data_in)
    );

    always_comb begin
        s_e    = sel ? lcd_e_t     : lcd_e;
        s_rw   = sel ? lcd_rw_t    : lcd_rw;
        s_rs   = sel ? lcd_rs_t    : lcd_rs;
        s_rdy  = sel ? ready_t     : ready;
        s_v    = sel ? rd_valid_t  : rd_valid;
        s_bf   = sel ? busy_flag_t : busy_flag;
        s_to   = sel ? timeout_t   : timeout;
        s_data = sel ? rd_data_t   : rd_data;
        s_addr = sel ? addr_t      : addr;
    end

    // Accept a request at edge k; returns #1 after edge k. Command inputs are
    // then flipped to show mid-operation changes are ignored.
    task automatic kick(input logic t, input logic rs, input logic pb);
        @(negedge clk);
        sel = t;
        cmd_rs = rs;
        poll_bf = pb;
        if (t) req_t = 1'b1; else req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        req_t = 1'b0;
        cmd_rs = ~rs;
        poll_bf = ~pb;
    endtask

    // Record n cycles; optionally change the bus at chg_j and pulse req at req_j
    task automatic record(input int n, input int chg_j, input logic [7:0] chg_val, input int req_j);
        n_valid = 0;
        v_at = -1;
        for (int j = 0; j < n; j++) begin
            if (j == chg_j) lcd_data_in = chg_val;
            req = (j == req_j);
            e_h[j] = s_e;
            rw_h[j] = s_rw;
            rs_h[j] = s_rs;
            rdy_h[j] = s_rdy;
            if (s_v) begin
                n_valid++;
                if (v_at < 0) begin
                    v_at = j;
                    v_data = s_data;
                    v_addr = s_addr;
                    v_bf = s_bf;
                    v_to = s_to;
                end
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
    endtask

    function automatic int pulses(input int n);
        int p = 0;
        for (int j = 0; j < n; j++)
            if (e_h[j] && (j == 0 || !e_h[j-1])) p++;
        return p;
    endfunction

    task automatic test_reset();
        n_reset = 1'b0;
        #10;
        checks++;
        if ({ready, rd_valid, timeout, busy_flag, rd_data, addr, lcd_e, lcd_rw, lcd_rs} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b v=%b to=%b bf=%b d=%h a=%h e=%b rw=%b rs=%b",
                     ready, rd_valid, timeout, busy_flag, rd_data, addr, lcd_e, lcd_rw, lcd_rs);
        end
        checks++;
        if ({ready_t, rd_valid_t, lcd_e_t, lcd_rw_t} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_outputs_t got %b exp 1000", {ready_t, rd_valid_t, lcd_e_t, lcd_rw_t});
        end
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_bfac_read();
        lcd_data_in = 8'h45;
        kick(1'b0, 1'b0, 1'b0);
        record(12, -1, 8'h00, -1);
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (e_h[j] !== (j >= 1 && j <= 4)) begin
                errors++;
                $display("FAIL bfac_e_j%0d got %b exp %b", j, e_h[j], (j >= 1 && j <= 4));
            end
        end
        checks++;
        if (rw_h[0] !== 1'b1 || rdy_h[0] !== 1'b0 || rw_h[9] !== 1'b0 || rdy_h[9] !== 1'b1) begin
            errors++;
            $display("FAIL bfac_rw_ready got rw0=%b rdy0=%b rw9=%b rdy9=%b exp 1 0 0 1",
                     rw_h[0], rdy_h[0], rw_h[9], rdy_h[9]);
        end
        checks++;
        if (v_at !== 9 || n_valid !== 1) begin
            errors++;
            $display("FAIL bfac_valid got at=%0d count=%0d exp at=9 count=1", v_at, n_valid);
        end
        checks++;
        if ({v_bf, v_addr, v_data, v_to} !== {1'b0, 7'h45, 8'h45, 1'b0}) begin
            errors++;
            $display("FAIL bfac_result got bf=%b a=%h d=%h to=%b exp 0 45 45 0", v_bf, v_addr, v_data, v_to);
        end
    endtask

    task automatic test_data_read();
        lcd_data_in = 8'h4D;
        kick(1'b0, 1'b1, 1'b0);
        record(12, -1, 8'h00, -1);
        for (int j = 0; j < 9; j++) begin
            checks++;
            if (rs_h[j] !== 1'b1) begin
                errors++;
                $display("FAIL data_rs_j%0d got %b exp 1", j, rs_h[j]);
            end
        end
        checks++;
        if (v_at !== 9 || n_valid !== 1 || rs_h[9] !== 1'b0) begin
            errors++;
            $display("FAIL data_valid got at=%0d count=%0d rs9=%b exp 9 1 0", v_at, n_valid, rs_h[9]);
        end
        checks++;
        if ({v_data, v_bf, v_addr} !== {8'h4D, 1'b0, 7'h45}) begin
            errors++;
            $display("FAIL data_result got d=%h bf=%b a=%h exp 4d 0 45", v_data, v_bf, v_addr);
        end
    endtask

    task automatic test_poll();
        lcd_data_in = 8'h80;
        kick(1'b0, 1'b0, 1'b1);
        // third sample is edge k+23; clear BF before the fourth at k+32
        record(40, 25, 8'h00, -1);
        checks++;
        if (pulses(40) !== 4) begin
            errors++;
            $display("FAIL poll_pulses got %0d exp 4", pulses(40));
        end
        checks++;
        if (v_at !== 36 || n_valid !== 1) begin
            errors++;
            $display("FAIL poll_valid got at=%0d count=%0d exp 36 1", v_at, n_valid);
        end
        checks++;
        if ({v_bf, v_to, v_addr} !== {1'b0, 1'b0, 7'h00}) begin
            errors++;
            $display("FAIL poll_result got bf=%b to=%b a=%h exp 0 0 00", v_bf, v_to, v_addr);
        end
    endtask

    task automatic test_poll_timeout();
        lcd_data_in = 8'hC0;
        kick(1'b1, 1'b0, 1'b1);
        record(50, -1, 8'h00, -1);
        checks++;
        if (pulses(50) !== 5) begin
            errors++;
            $display("FAIL tmo_pulses got %0d exp 5", pulses(50));
        end
        checks++;
        if (v_at !== 45 || n_valid !== 1) begin
            errors++;
            $display("FAIL tmo_valid got at=%0d count=%0d exp 45 1", v_at, n_valid);
        end
        checks++;
        if ({v_to, v_bf, v_addr} !== {1'b1, 1'b1, 7'h40}) begin
            errors++;
            $display("FAIL tmo_result got to=%b bf=%b a=%h exp 1 1 40", v_to, v_bf, v_addr);
        end
        sel = 1'b0;
    endtask

    task automatic test_ignored_req();
        lcd_data_in = 8'h21;
        kick(1'b0, 1'b0, 1'b0);
        // req high across edge k+3
        record(14, -1, 8'h00, 2);
        checks++;
        if (pulses(14) !== 1) begin
            errors++;
            $display("FAIL ign_pulses got %0d exp 1", pulses(14));
        end
        for (int j = 0; j < 14; j++) begin
            checks++;
            if (rdy_h[j] !== (j >= 9)) begin
                errors++;
                $display("FAIL ign_ready_j%0d got %b exp %b", j, rdy_h[j], (j >= 9));
            end
        end
        checks++;
        if (v_at !== 9 || n_valid !== 1 || v_data !== 8'h21) begin
            errors++;
            $display("FAIL ign_valid got at=%0d count=%0d d=%h exp 9 1 21", v_at, n_valid, v_data);
        end
    endtask

    task automatic test_reset_mid();
        lcd_data_in = 8'h33;
        kick(1'b0, 1'b0, 1'b0);
        record(3, -1, 8'h00, -1);
        // now #1 after edge k+3 with E high
        checks++;
        if (lcd_e !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre_e got %b exp 1", lcd_e);
        end
        n_reset = 1'b0;
        #1;
        checks++;
        if ({lcd_e, lcd_rw, ready, rd_valid, rd_data} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rst_mid got e=%b rw=%b rdy=%b v=%b d=%h exp 0 0 1 0 00",
                     lcd_e, lcd_rw, ready, rd_valid, rd_data);
        end
        @(negedge clk);
        n_reset = 1'b1;
        record(10, -1, 8'h00, -1);
        checks++;
        if (n_valid !== 0 || pulses(10) !== 0) begin
            errors++;
            $display("FAIL rst_mid_quiet got valid=%0d pulses=%0d exp 0 0", n_valid, pulses(10));
        end
        lcd_data_in = 8'h12;
        kick(1'b0, 1'b0, 1'b0);
        record(12, -1, 8'h00, -1);
        checks++;
        if (v_at !== 9 || n_valid !== 1 || v_addr !== 7'h12 || v_data !== 8'h12) begin
            errors++;
            $display("FAIL rst_mid_after got at=%0d count=%0d a=%h d=%h exp 9 1 12 12",
                     v_at, n_valid, v_addr, v_data);
        end
    endtask

    initial begin
        #10;
        test_reset();
        test_bfac_read();
        test_data_read();
        test_poll();
        test_poll_timeout();
        test_ignored_req();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
